// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pipe_pkg
// Description : Shared definitions for the RISC-V pipeline: the packed
//               control-bundle layout, the default register-address width,
//               the bubble control value and a load-detection helper.
// Revision    : 1.0  initial release
// ============================================================================
package rv_pipe_pkg;

  // Control bundle: {ALUSrc, mem2reg, RegWrite, memRead, memWrite, branch, ALUOp[1:0]}
  localparam int CTRL_W        = 8;
  localparam int CTRL_ALUSRC   = 7;
  localparam int CTRL_MEM2REG  = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_MEMREAD  = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  localparam int REG_AW_DEF = 5;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // An entry only counts as a load when it is real, reads memory and
  // targets a register other than x0.
  function automatic logic is_load(input logic              valid,
                                   input logic [CTRL_W-1:0] ctrl,
                                   input logic              rd_nonzero);
    return valid & ctrl[CTRL_MEMREAD] & rd_nonzero;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module      : load_hazard_tracker
// Description : Tracks recent loads across a LOAD_LAT-deep window and flags a
//               load-use hazard for the instruction sitting in ID.
//               Slot 0 is supplied by the ID/EX register; slots 1..LOAD_LAT-1
//               are a local shadow shift register that advances with EX.
// Ports       : clk, rst          clock, async active-high reset
//               advance           EX accepted an entry this cycle
//               slot0_load/rd     load info of the current ID/EX entry
//               id_valid, flush   ID qualification
//               uses_rs1/2, rs1/2 source usage and addresses of ID instr
//               load_use          hazard: ID must not issue this cycle
// Revision    : 1.0  initial release
// ============================================================================
module load_hazard_tracker #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              slot0_load,
  input  logic [REG_AW-1:0] slot0_rd,
  input  logic              id_valid,
  input  logic              flush,
  input  logic              uses_rs1,
  input  logic              uses_rs2,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              load_use
);

  // Flattened window: bit/field i describes slot i (0 = ID/EX register).
  logic [LOAD_LAT-1:0]        w_win_v;
  logic [LOAD_LAT*REG_AW-1:0] w_win_rd;
  logic                       w_hit1;
  logic                       w_hit2;

  generate
    if (LOAD_LAT > 1) begin : g_shadow
      logic [LOAD_LAT-2:0]            r_sh_v;
      logic [(LOAD_LAT-1)*REG_AW-1:0] r_sh_rd;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sh_v  <= '0;
          r_sh_rd <= '0;
        end else if (advance) begin
          r_sh_v[0]            <= slot0_load;
          r_sh_rd[0 +: REG_AW] <= slot0_load ? slot0_rd : '0;
          for (int i = 1; i < LOAD_LAT-1; i++) begin
            r_sh_v[i]                   <= r_sh_v[i-1];
            r_sh_rd[i*REG_AW +: REG_AW] <= r_sh_rd[(i-1)*REG_AW +: REG_AW];
          end
        end
      end

      assign w_win_v  = {r_sh_v, slot0_load};
      assign w_win_rd = {r_sh_rd, slot0_rd};
    end else begin : g_no_shadow
      assign w_win_v  = slot0_load;
      assign w_win_rd = slot0_rd;
    end
  endgenerate

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (w_win_v[i] && (w_win_rd[i*REG_AW +: REG_AW] == rs1)) w_hit1 = 1'b1;
      if (w_win_v[i] && (w_win_rd[i*REG_AW +: REG_AW] == rs2)) w_hit2 = 1'b1;
    end
  end

  // x0 is hardwired zero, so a read of x0 never depends on a load.
  assign load_use = id_valid & ~flush &
                    ((uses_rs1 & (rs1 != '0) & w_hit1) |
                     (uses_rs2 & (rs2 != '0) & w_hit2));

endmodule
`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_hazard_stage
// Description : Hazard-aware ID/EX pipeline register. Registers decoded
//               operands/control toward EX, inserts bubbles on load-use
//               hazards and redirect flushes, honours EX back-pressure and
//               counts load-use bubble cycles (saturating).
// Ports       : clk, rst                     clock, async active-high reset
//               id_*                         decoded instruction from ID
//               ex_ready, flush              EX acceptance, redirect kill
//               stall_ifid                   hold PC and IF/ID
//               ex_*                         registered ID/EX entry
//               stall_cnt                    load-use bubble counter
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_hazard_stage #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = rv_pipe_pkg::REG_AW_DEF,
  parameter int CTRL_W   = rv_pipe_pkg::CTRL_W,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_ready,
  input  logic              flush,
  output logic              stall_ifid,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [31:0]       ex_instr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [CNT_W-1:0]  stall_cnt
);

  import rv_pipe_pkg::*;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [31:0]       r_instr;
  logic [CTRL_W-1:0] r_ctrl;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_load_use;
  logic              w_slot0_load;
  logic [REG_AW-1:0] w_id_rs1;
  logic [REG_AW-1:0] w_id_rs2;
  logic [REG_AW-1:0] w_id_rd;

  assign w_id_rd  = id_instr[7 +: REG_AW];
  assign w_id_rs1 = id_instr[15 +: REG_AW];
  assign w_id_rs2 = id_instr[20 +: REG_AW];

  assign w_slot0_load = is_load(r_valid, r_ctrl, r_rd != '0);

  load_hazard_tracker #(
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .advance    (ex_ready),
    .slot0_load (w_slot0_load),
    .slot0_rd   (r_rd),
    .id_valid   (id_valid),
    .flush      (flush),
    .uses_rs1   (id_uses_rs1),
    .uses_rs2   (id_uses_rs2),
    .rs1        (w_id_rs1),
    .rs2        (w_id_rs2),
    .load_use   (w_load_use)
  );

  // A redirect overrides both the hazard and back-pressure holds: the ID
  // instruction is dead, so IF must move on to the new target.
  assign stall_ifid = (w_load_use | ~ex_ready) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_instr     <= '0;
      r_ctrl      <= CTRL_BUBBLE;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_stall_cnt <= '0;
    end else if (ex_ready) begin
      // Data fields always follow ID; they are meaningless in a bubble.
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_instr    <= id_instr;
      r_rs1      <= w_id_rs1;
      r_rs2      <= w_id_rs2;
      // w_load_use is already masked by flush.
      if (flush || w_load_use) begin
        r_valid <= 1'b0;
        r_ctrl  <= CTRL_BUBBLE;
        r_rd    <= '0;
      end else begin
        r_valid <= id_valid;
        r_ctrl  <= id_valid ? id_ctrl : CTRL_BUBBLE;
        r_rd    <= w_id_rd;
      end
      if (w_load_use && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_instr    = r_instr;
  assign ex_ctrl     = r_ctrl;
  assign ex_rd       = r_rd;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_hazard_stage
// Description : Self-checking bench. Two lanes run side by side:
//               lane 0 = LOAD_LAT 1 / 16-bit counter, lane 1 = LOAD_LAT 3 /
//               3-bit counter. A reference model built on the history of the
//               last LOAD_LAT entries accepted by EX predicts each entry; a
//               monitor compares the registered outputs every cycle.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_id_ex_hazard_stage;
  import rv_pipe_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int CW0  = 16;
  localparam int CW1  = 3;

  typedef struct {
    logic        v;
    logic [31:0] instr, pc, r1d, r2d, imm;
    logic [7:0]  ctrl;
    logic        u1, u2;
  } id_t;

  typedef struct {
    int          lane;
    logic        bub;
    logic        v;
    logic [7:0]  ctrl;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, instr, r1d, r2d, imm;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        id_valid[2];
  logic [31:0] id_instr[2], id_pc[2], id_rs1_data[2], id_rs2_data[2], id_imm[2];
  logic [7:0]  id_ctrl[2];
  logic        id_uses_rs1[2], id_uses_rs2[2], ex_ready[2], flush[2];
  logic        stall_ifid[2], ex_valid[2];
  logic [31:0] ex_pc[2], ex_rs1_data[2], ex_rs2_data[2], ex_imm[2], ex_instr[2];
  logic [7:0]  ex_ctrl[2];
  logic [4:0]  ex_rd[2], ex_rs1[2], ex_rs2[2];
  logic [CW0-1:0] cnt0;
  logic [CW1-1:0] cnt1;

  id_ex_hazard_stage #(.XLEN(32), .REG_AW(5), .CTRL_W(8), .LOAD_LAT(LAT0), .CNT_W(CW0)) u_dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid[0]), .id_instr(id_instr[0]), .id_pc(id_pc[0]),
    .id_rs1_data(id_rs1_data[0]), .id_rs2_data(id_rs2_data[0]), .id_imm(id_imm[0]),
    .id_ctrl(id_ctrl[0]), .id_uses_rs1(id_uses_rs1[0]), .id_uses_rs2(id_uses_rs2[0]),
    .ex_ready(ex_ready[0]), .flush(flush[0]), .stall_ifid(stall_ifid[0]), .ex_valid(ex_valid[0]),
    .ex_pc(ex_pc[0]), .ex_rs1_data(ex_rs1_data[0]), .ex_rs2_data(ex_rs2_data[0]), .ex_imm(ex_imm[0]),
    .ex_instr(ex_instr[0]), .ex_ctrl(ex_ctrl[0]), .ex_rd(ex_rd[0]), .ex_rs1(ex_rs1[0]),
    .ex_rs2(ex_rs2[0]), .stall_cnt(cnt0));

  id_ex_hazard_stage #(.XLEN(32), .REG_AW(5), .CTRL_W(8), .LOAD_LAT(LAT1), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid[1]), .id_instr(id_instr[1]), .id_pc(id_pc[1]),
    .id_rs1_data(id_rs1_data[1]), .id_rs2_data(id_rs2_data[1]), .id_imm(id_imm[1]),
    .id_ctrl(id_ctrl[1]), .id_uses_rs1(id_uses_rs1[1]), .id_uses_rs2(id_uses_rs2[1]),
    .ex_ready(ex_ready[1]), .flush(flush[1]), .stall_ifid(stall_ifid[1]), .ex_valid(ex_valid[1]),
    .ex_pc(ex_pc[1]), .ex_rs1_data(ex_rs1_data[1]), .ex_rs2_data(ex_rs2_data[1]), .ex_imm(ex_imm[1]),
    .ex_instr(ex_instr[1]), .ex_ctrl(ex_ctrl[1]), .ex_rd(ex_rd[1]), .ex_rs1(ex_rs1[1]),
    .ex_rs2(ex_rs2[1]), .stall_cnt(cnt1));

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- reference model state ----------------
  exp_t q[$];
  exp_t cur[2];
  logic adv[2];
  id_t  pend[2];
  logic hold[2];
  id_t  dq0[$], dq1[$];
  int   hist[2][4];   // rd of the last accepted entries if they were loads, else 0
  int   mcnt[2];
  logic rnd_mode;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic int lat(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int maxc(input int k);
    return (k == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
  endfunction

  function automatic int dut_cnt(input int k);
    return (k == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  function automatic logic inwin(input int k, input logic [4:0] r);
    for (int i = 0; i < lat(k); i++) if (hist[k][i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic id_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic ld);
    id_t p;
    p.v     = 1'b1;
    p.instr = {7'b0, rs2, rs1, 3'b010, rd, (ld ? 7'b0000011 : 7'b0110011)};
    p.ctrl  = ld ? 8'hF0 : 8'h22;
    p.u1    = u1;
    p.u2    = u2;
    p.pc    = 32'h0;
    p.r1d   = $urandom;
    p.r2d   = $urandom;
    p.imm   = $urandom;
    return p;
  endfunction

  function automatic id_t rand_instr();
    id_t p;
    p = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    p.ctrl = 8'($urandom);
    p.ctrl[CTRL_MEMREAD] = ($urandom_range(0, 2) == 0);
    p.v = ($urandom_range(0, 9) != 0);
    return p;
  endfunction

  task automatic next_instr(input int k);
    id_t p;
    if (k == 0 && dq0.size() > 0)      p = dq0.pop_front();
    else if (k == 1 && dq1.size() > 0) p = dq1.pop_front();
    else if (rnd_mode)                 p = rand_instr();
    else begin
      p = mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      p.v = 1'b0;
    end
    pc_ctr = pc_ctr + 32'd4;
    p.pc = pc_ctr;
    pend[k] = p;
  endtask

  task automatic push_dir(input id_t p);
    dq0.push_back(p);
    dq1.push_back(p);
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
  endtask

  task automatic clear_model();
    exp_t z;
    z = '{lane: 0, bub: 1'b0, v: 1'b0, ctrl: 8'h0, rd: 5'h0, rs1: 5'h0, rs2: 5'h0,
          pc: 32'h0, instr: 32'h0, r1d: 32'h0, r2d: 32'h0, imm: 32'h0, cnt: 0};
    q.delete();
    for (int k = 0; k < 2; k++) begin
      z.lane = k;
      cur[k] = z;
      mcnt[k] = 0;
      hold[k] = 1'b0;
      for (int i = 0; i < 4; i++) hist[k][i] = 0;
    end
  endtask

  // Predict this cycle's stall and, if EX accepts, the next ID/EX entry.
  task automatic model_cycle(input int k, input logic rdy, input logic fl);
    id_t p;
    exp_t e;
    logic [4:0] rd, rs1, rs2;
    logic lu, st;
    p   = pend[k];
    rd  = p.instr[11:7];
    rs1 = p.instr[19:15];
    rs2 = p.instr[24:20];
    lu  = p.v && !fl && ((p.u1 && rs1 != 0 && inwin(k, rs1)) || (p.u2 && rs2 != 0 && inwin(k, rs2)));
    st  = (lu || !rdy) && !fl;
    n_chk++;
    if (stall_ifid[k] === st) n_pass++;
    else $display("FAIL stall_ifid lane%0d: got %b expected %b (t=%0t)", k, stall_ifid[k], st, $time);
    hold[k] = st;
    if (rdy) begin
      if (lu && mcnt[k] < maxc(k)) mcnt[k]++;
      e.lane  = k;
      e.bub   = fl || lu;
      e.v     = p.v && !e.bub;
      e.ctrl  = e.v ? p.ctrl : 8'h0;
      e.rd    = e.bub ? 5'd0 : rd;
      e.rs1   = rs1;
      e.rs2   = rs2;
      e.pc    = p.pc;
      e.instr = p.instr;
      e.r1d   = p.r1d;
      e.r2d   = p.r2d;
      e.imm   = p.imm;
      e.cnt   = mcnt[k];
      for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = (e.v && p.ctrl[CTRL_MEMREAD] && rd != 0) ? int'(rd) : 0;
      q.push_back(e);
    end
  endtask

  // One clock: apply ID inputs at the falling edge, then check stall.
  task automatic step(input logic r0, input logic f0, input logic r1, input logic f1);
    logic rr[2];
    logic ff[2];
    rr[0] = r0; rr[1] = r1; ff[0] = f0; ff[1] = f1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (!hold[k]) next_instr(k);
      id_valid[k]    = pend[k].v;
      id_instr[k]    = pend[k].instr;
      id_pc[k]       = pend[k].pc;
      id_rs1_data[k] = pend[k].r1d;
      id_rs2_data[k] = pend[k].r2d;
      id_imm[k]      = pend[k].imm;
      id_ctrl[k]     = pend[k].ctrl;
      id_uses_rs1[k] = pend[k].u1;
      id_uses_rs2[k] = pend[k].u2;
      ex_ready[k]    = rr[k];
      flush[k]       = ff[k];
    end
    #1;
    for (int k = 0; k < 2; k++) model_cycle(k, rr[k], ff[k]);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) for (int k = 0; k < 2; k++) adv[k] = ex_ready[k] && !rst;

  task automatic check_out(input int k);
    exp_t e;
    logic ok;
    e = cur[k];
    ok = (e.lane == k) && (ex_valid[k] === e.v) && (ex_ctrl[k] === e.ctrl) &&
         (ex_rd[k] === e.rd) && (dut_cnt(k) == e.cnt);
    if (!e.bub)
      ok = ok && (ex_pc[k] === e.pc) && (ex_instr[k] === e.instr) && (ex_rs1_data[k] === e.r1d) &&
           (ex_rs2_data[k] === e.r2d) && (ex_imm[k] === e.imm) && (ex_rs1[k] === e.rs1) &&
           (ex_rs2[k] === e.rs2);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL ex_entry lane%0d t=%0t: got v=%b ctrl=%h rd=%0d pc=%h instr=%h cnt=%0d, expected v=%b ctrl=%h rd=%0d pc=%h instr=%h cnt=%0d",
                  k, $time, ex_valid[k], ex_ctrl[k], ex_rd[k], ex_pc[k], ex_instr[k], dut_cnt(k),
                  e.v, e.ctrl, e.rd, e.pc, e.instr, e.cnt);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (adv[k]) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard lane%0d: got empty queue expected an entry (t=%0t)", k, $time);
        end else cur[k] = q.pop_front();
      end
      check_out(k);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic r0, r1, f0, f1;
    for (int k = 0; k < 2; k++) begin
      id_valid[k] = 0; id_instr[k] = 0; id_pc[k] = 0; id_rs1_data[k] = 0; id_rs2_data[k] = 0;
      id_imm[k] = 0; id_ctrl[k] = 0; id_uses_rs1[k] = 0; id_uses_rs2[k] = 0;
      ex_ready[k] = 1; flush[k] = 0; adv[k] = 0;
    end
    clear_model();
    rnd_mode = 1'b1;

    // Randomized traffic with back-pressure and flushes (flush only when EX accepts).
    for (int i = 0; i < 600; i++) begin
      r0 = ($urandom_range(0, 9) < 8);
      r1 = ($urandom_range(0, 9) < 8);
      f0 = r0 && ($urandom_range(0, 19) == 0);
      f1 = r1 && ($urandom_range(0, 19) == 0);
      step(r0, f0, r1, f1);
    end

    // Asynchronous reset mid-stall with a real load in ID/EX.
    rnd_mode = 1'b0;
    run_idle(5);
    push_dir(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1));
    run_idle(1);
    push_dir(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0));
    run_idle(1);
    #1;
    chk("pre_reset_ex_valid_l0", int'(ex_valid[0]), 1);
    chk("pre_reset_ex_valid_l1", int'(ex_valid[1]), 1);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_reset_ex_valid", int'(ex_valid[k]), 0);
      chk("async_reset_ex_ctrl",  int'(ex_ctrl[k]), 0);
      chk("async_reset_ex_pc",    int'(ex_pc[k]), 0);
      chk("async_reset_ex_rd",    int'(ex_rd[k]), 0);
      chk("async_reset_stall",    int'(stall_ifid[k]), 0);
      chk("async_reset_cnt",      dut_cnt(k), 0);
    end
    clear_model();
    dq0.delete();
    dq1.delete();
    run_idle(4);

    // lw x5 ; add x6,x5,x1 : LOAD_LAT bubbles.
    push_dir(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1));
    push_dir(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0));
    run_idle(8);
    chk("lw_add_cnt_l0", dut_cnt(0), 1);
    chk("lw_add_cnt_l1", dut_cnt(1), 3);

    // Independent instruction between load and consumer.
    push_dir(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1));
    push_dir(mk(5'd7, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0));
    push_dir(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0));
    run_idle(8);
    chk("lw_gap_add_cnt_l0", dut_cnt(0), 1);
    chk("lw_gap_add_cnt_l1", dut_cnt(1), 5);

    // lw x0 then use of x0; lw x5 then lui x5 (no sources).
    push_dir(mk(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1));
    push_dir(mk(5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0));
    push_dir(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1));
    push_dir(mk(5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0));
    run_idle(8);
    chk("x0_lui_cnt_l0", dut_cnt(0), 1);
    chk("x0_lui_cnt_l1", dut_cnt(1), 5);

    // Back-pressure for 4 cycles with the load in slot 0; counter saturates on lane 1.
    push_dir(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1));
    push_dir(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0));
    run_idle(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("backpressure_hold_cnt_l1", dut_cnt(1), 5);
    run_idle(8);
    chk("backpressure_cnt_l0", dut_cnt(0), 2);
    chk("backpressure_sat_cnt_l1", dut_cnt(1), 7);

    // Flush coincident with a load-use hazard.
    push_dir(mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1));
    push_dir(mk(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0));
    run_idle(1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush_stall_l0", int'(stall_ifid[0]), 0);
    chk("flush_stall_l1", int'(stall_ifid[1]), 0);
    run_idle(6);
    chk("flush_cnt_l0", dut_cnt(0), 2);
    chk("flush_cnt_l1", dut_cnt(1), 7);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- Parametrised, hazard-aware ID/EX pipeline stage for the RISC-V pipeline.
- Takes decoded operands and control from decode, then registers them toward EX.
- Detects load-use hazards against a configurable load-latency window and inserts bubbles.
- Honours back-pressure from EX and redirect flushes, and keeps a saturating stall counter.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- REG_AW, 5, register address width.
- CTRL_W, 8, width of the packed control bundle {ALUSrc, mem2reg, RegWrite, memRead, memWrite, branch, ALUOp[1:0]}.
- LOAD_LAT, 1, number of younger instructions that cannot consume a load result (1 = classic single bubble). Legal range 1..4.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_instr  in  32  instruction word.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data / id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  control bundle from the control unit.
- id_uses_rs1 / id_uses_rs2  in  1  the instruction reads that source.
- ex_ready  in  1  EX can accept a new entry this cycle.
- flush  in  1  redirect: kill the instruction currently in ID.
- stall_ifid  out  1  hold the PC and the IF/ID register.
- ex_valid  out  1  ID/EX entry is real.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies.
- ex_instr  out  32  registered instruction.
- ex_ctrl  out  CTRL_W  registered control; all zero when ex_valid=0.
- ex_rd, ex_rs1, ex_rs2  out  REG_AW  instr[11:7], [19:15], [24:20] as registered.
- stall_cnt  out  CNT_W  count of load-use bubble cycles.

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - All ex_* outputs are 0 and ex_valid=0.
  - The shadow window is cleared and stall_cnt=0.
  - stall_ifid is combinational and reads 0 immediately after reset.
- Load tracking:
  - A load is an entry with ex_ctrl memRead=1, ex_valid=1 and ex_rd!=0.
  - Slot 0 is the ID/EX register itself.
  - Slots 1..LOAD_LAT-1 form a shadow shift register {v, rd}.
  - On every cycle with ex_ready=1, slot1 takes the slot-0 load info (v=0 if slot 0 is not a load) and the other slots shift up.
  - When ex_ready=0 the shadow holds.
- Load-use hazard:
  - load_use = id_valid & ~flush & ((id_uses_rs1 & rs1!=0 & rs1 matches any valid slot rd) | (the same check for rs2)).
  - Register x0 never hazards.
- stall_ifid = (load_use | ~ex_ready) & ~flush.
- ID/EX update, evaluated in priority order:
  1. ex_ready=0: hold all ID/EX contents.
  2. flush=1: load a bubble (ex_valid=0, ex_ctrl=0, ex_rd=0). Other data fields load from ID and are don't-care.
  3. load_use: load a bubble.
  4. Otherwise: load from ID; ex_valid=id_valid and ex_ctrl=id_ctrl masked to zero when id_valid=0.
- Flush is meaningful only when ex_ready=1. The redirect source holds flush until accepted.
- Latency: one cycle from ID to the ex_* outputs.
- With LOAD_LAT=L, a dependent instruction directly behind a load sees exactly L bubble cycles.
- stall_cnt increments by 1 on each cycle with ex_ready & load_use. It saturates at all-ones and never wraps.

Decomposition:
- Shared package rv_pipe_pkg:
  - CTRL_W and the control-bundle bit indices (CTRL_ALUSRC=7 … CTRL_ALUOP=1:0).
  - The REG_AW default.
  - The CTRL_BUBBLE=0 constant.
- One sub-module, load_hazard_tracker:
  - Contains the shadow shift register and the source compare.
  - Outputs load_use.

Test Plan:
- Reset: assert rst mid-stream with ex_valid=1 → all outputs 0 asynchronously, before the next clk edge; stall_cnt=0.
- Load-use, LOAD_LAT=1: lw x5 then add x6,x5,x1 → one cycle with stall_ifid=1 and a bubble (ex_valid=0, ex_ctrl=0). The add then enters ID/EX, and stall_cnt=1.
- LOAD_LAT=3: lw x5 then add using x5 → 3 bubbles and stall_cnt=3. An independent add x7,x2,x3 between them shortens this to 2 bubbles.
- x0 and unused-source cases:
  - lw x0 followed by a use of x0 → no stall.
  - lui x5 (id_uses_rs1=0) behind lw x5 → no stall.
- Back-pressure: ex_ready=0 for 4 cycles while a load is in slot 0 → ID/EX and shadow held, stall_ifid=1, stall_cnt unchanged. After release, exactly LOAD_LAT bubbles follow.
- Flush versus hazard: flush=1 together with load_use=1 and ex_ready=1 → stall_ifid=0, a bubble is inserted, and stall_cnt does not increment.
